// File: rtl/toggle_activity_monitor.sv
// toggle_activity_monitor
// Counts edge-sampled transitions on each monitored net over a window of
// WIN_LEN compared sample pairs. It then streams one (index, count) beat per
// net over a valid/ready handshake, together with the window total.
// Build option: define TOGGLE_MON_SAT_EN to make the per-net counters and the
// total saturate at all-ones. When it is not defined, they wrap.
module toggle_activity_monitor #(
  parameter int N_NETS  = 8,
  parameter int CNT_W   = 16,
  parameter int WIN_LEN = 256
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [N_NETS-1:0]                 nets_in,
  input  logic                              start,
  output logic                              busy,
  output logic                              res_valid,
  input  logic                              res_ready,
  output logic [$clog2(N_NETS)-1:0]         res_idx,
  output logic [CNT_W-1:0]                  res_count,
  output logic                              res_last,
  output logic [CNT_W+$clog2(N_NETS)-1:0]   total_count
);

  localparam int IDX_W = $clog2(N_NETS);
  localparam int TOT_W = CNT_W + IDX_W;
  localparam int WIN_W = $clog2(WIN_LEN + 1);
  localparam int POP_W = $clog2(N_NETS + 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_NETS - 1);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WIN_LEN);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t             state_reg, state_next;
  logic               start_q_reg;
  logic [WIN_W-1:0]   win_cnt_reg;
  logic [N_NETS-1:0]  prev_reg;
  logic [N_NETS-1:0]  tog;
  logic [CNT_W-1:0]   cnt_q [N_NETS];
  logic [CNT_W-1:0]   cnt_d [N_NETS];
  logic [TOT_W-1:0]   total_reg, total_d;
  logic [TOT_W:0]     total_sum;
  logic [POP_W-1:0]   pop;
  logic [IDX_W-1:0]   idx_reg, idx_next;
  logic [CNT_W-1:0]   count_reg;
  logic               busy_reg, valid_reg, last_reg;
  logic               clear, counting, beat_done;

  // The first RUN cycle only loads the baseline. Every later RUN cycle is a compare.
  assign clear     = (state_reg == IDLE) && start_q_reg;
  assign counting  = (state_reg == RUN) && (win_cnt_reg != '0);
  assign beat_done = valid_reg && res_ready;
  assign tog       = nets_in ^ prev_reg;

  // Register the start request. Only an IDLE sample is taken, so a start seen
  // on the final handshake edge of DRAIN is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) start_q_reg <= 1'b0;
    else     start_q_reg <= (state_reg == IDLE) && !start_q_reg && start;
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // FSM next-state and next beat index
  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    case (state_reg)
      IDLE:    if (start_q_reg) state_next = RUN;
      RUN:     if (win_cnt_reg == WIN_LAST) state_next = DRAIN;
      DRAIN:   if (beat_done && (idx_reg == IDX_LAST)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (state_next != DRAIN)
      idx_next = '0;
    else if ((state_reg == DRAIN) && beat_done)
      idx_next = idx_reg + 1'b1;
  end

  // Window position: counts the baseline cycle plus WIN_LEN compares.
  // It also keeps the last sample for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_cnt_reg <= '0;
      prev_reg    <= '0;
    end else begin
      if (clear)
        win_cnt_reg <= '0;
      else if ((state_reg == RUN) && (state_next == RUN))
        win_cnt_reg <= win_cnt_reg + 1'b1;
      if (state_reg == RUN)
        prev_reg <= nets_in;
    end
  end

  // One toggle counter per net
  generate
    for (genvar gi = 0; gi < N_NETS; gi++) begin : g_net
      logic [CNT_W-1:0] cnt_reg;
      logic [CNT_W-1:0] inc;
`ifdef TOGGLE_MON_SAT_EN
      assign inc = (cnt_reg == '1) ? cnt_reg : cnt_reg + 1'b1;
`else
      assign inc = cnt_reg + 1'b1;
`endif
      assign cnt_d[gi] = clear ? '0 : ((counting && tog[gi]) ? inc : cnt_reg);
      assign cnt_q[gi] = cnt_reg;

      // Per-net counter register
      always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_reg <= '0;
        else     cnt_reg <= cnt_d[gi];
      end
    end
  endgenerate

  // Window total: add the number of nets that toggled this cycle
  always_comb begin
    pop = '0;
    for (int i = 0; i < N_NETS; i++)
      pop = pop + POP_W'(tog[i]);
    total_sum = {1'b0, total_reg} + (TOT_W + 1)'(pop);
    total_d   = total_reg;
    if (clear)
      total_d = '0;
    else if (counting) begin
`ifdef TOGGLE_MON_SAT_EN
      total_d = total_sum[TOT_W] ? '1 : total_sum[TOT_W-1:0];
`else
      total_d = total_sum[TOT_W-1:0];
`endif
    end
  end

  // Total register. It holds its value from DRAIN until the next start is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) total_reg <= '0;
    else     total_reg <= total_d;
  end

  // Registered result-stream outputs. They are computed from next-state values,
  // so they are valid in the first DRAIN cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_reg  <= 1'b0;
      valid_reg <= 1'b0;
      idx_reg   <= '0;
      count_reg <= '0;
      last_reg  <= 1'b0;
    end else begin
      busy_reg  <= (state_next != IDLE);
      valid_reg <= (state_next == DRAIN);
      idx_reg   <= idx_next;
      count_reg <= (state_next == DRAIN) ? cnt_d[idx_next] : '0;
      last_reg  <= (state_next == DRAIN) && (idx_next == IDX_LAST);
    end
  end

  assign busy        = busy_reg;
  assign res_valid   = valid_reg;
  assign res_idx     = idx_reg;
  assign res_count   = count_reg;
  assign res_last    = last_reg;
  assign total_count = total_reg;

endmodule

// File: tb/tb_toggle_activity_monitor.sv
// Bench for toggle_activity_monitor with N_NETS=4, CNT_W=3 and WIN_LEN=8.
// The narrow counters make the overflow behaviour visible.
// It follows the TOGGLE_MON_SAT_EN build option in the same way as the design.
module tb_toggle_activity_monitor;
  localparam int N  = 4;
  localparam int CW = 3;
  localparam int WL = 8;
  localparam int IW = 2;
  localparam int TW = CW + IW;

  logic          clk, rst, start, res_ready, busy, res_valid, res_last;
  logic [N-1:0]  nets_in;
  logic [IW-1:0] res_idx;
  logic [CW-1:0] res_count;
  logic [TW-1:0] total_count;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [N-1:0] s [WL+1];
    int           ec [N];
    int           et;
    int           hold_idx;
    int           hold_n;
    bit           pulse;
    bit           end_start;
  } vec_t;

  vec_t         vt [5];
  logic [N-1:0] cur_samp [WL+1];
  int           cur_exp [N];
  int           cur_tot;

  toggle_activity_monitor #(.N_NETS(N), .CNT_W(CW), .WIN_LEN(WL)) dut (
    .clk(clk), .rst(rst), .nets_in(nets_in), .start(start), .busy(busy),
    .res_valid(res_valid), .res_ready(res_ready), .res_idx(res_idx),
    .res_count(res_count), .res_last(res_last), .total_count(total_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Apply the counter width rule to a raw toggle count
  function automatic int limit(input int raw, input int width);
    int maxv;
    maxv = (1 << width) - 1;
`ifdef TOGGLE_MON_SAT_EN
    return (raw > maxv) ? maxv : raw;
`else
    return raw % (maxv + 1);
`endif
  endfunction

  // Reference: count the differing adjacent samples per net, then apply the width rules
  function automatic void model();
    int raw;
    int tot;
    tot = 0;
    for (int i = 0; i < N; i++) begin
      raw = 0;
      for (int j = 1; j <= WL; j++)
        if (cur_samp[j][i] != cur_samp[j-1][i]) raw++;
      tot += raw;
      cur_exp[i] = limit(raw, CW);
    end
    cur_tot = limit(tot, TW);
  endfunction

  task automatic run_window(input int hold_idx, input int hold_n, input bit pulse,
                            input bit end_start, input int abort_idx);
    int  exp_i, held, guard;
    bit  rdy;
    @(negedge clk); start = 1'b1; nets_in = N'($urandom);
    @(negedge clk); start = 1'b0; nets_in = N'($urandom);
    chk("busy_after_start_edge", busy, 0);
    for (int j = 0; j <= WL; j++) begin
      @(negedge clk);
      nets_in = cur_samp[j];
      start   = pulse && (j == 4);
      if (j == 0) chk("busy_in_run", busy, 1);
      if (j == WL) chk("valid_not_early", res_valid, 0);
    end
    start = 1'b0;
    exp_i = 0; held = 0; guard = 0;
    while (exp_i < N && guard < 40) begin
      @(negedge clk);
      guard++;
      nets_in = N'($urandom);
      start   = pulse && (exp_i == 0);
      if (abort_idx == exp_i) begin
        res_ready = 1'b0;
        rst = 1'b1;
        #1;
        chk("abort_valid", res_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_idx", res_idx, 0);
        chk("abort_total", total_count, 0);
        $display("abort at idx %0d", exp_i);
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        return;
      end
      chk("beat_valid", res_valid, 1);
      chk("beat_idx", res_idx, exp_i);
      chk("beat_count", res_count, cur_exp[exp_i]);
      chk("beat_last", res_last, (exp_i == N - 1) ? 1 : 0);
      chk("total", total_count, cur_tot);
      rdy = !((exp_i == hold_idx) && (held < hold_n));
      res_ready = rdy;
      if (end_start && exp_i == N - 1 && rdy) start = 1'b1;
      $display("beat idx=%0d count=%0d last=%0b total=%0d ready=%0b",
               res_idx, res_count, res_last, total_count, rdy);
      if (rdy) exp_i++;
      else     held++;
    end
    if (guard >= 40) begin
      n_cmp++; n_err++;
      $display("FAIL drain_timeout: got %0d beats expected %0d", exp_i, N);
    end
    @(negedge clk);
    start = 1'b0; res_ready = 1'b0;
    chk("busy_after_last", busy, 0);
    chk("valid_after_last", res_valid, 0);
    if (end_start) begin
      repeat (2) @(negedge clk);
      chk("end_start_ignored", busy, 0);
    end
  endtask

  task automatic load_vec(input int v);
    for (int j = 0; j <= WL; j++) cur_samp[j] = vt[v].s[j];
    for (int i = 0; i < N; i++) cur_exp[i] = vt[v].ec[i];
    cur_tot = vt[v].et;
  endtask

  initial begin
    // Directed vectors: samples (baseline first), expected counts, and handshake shaping
    vt[0].s = '{4'h0, 4'h1, 4'h0, 4'h1, 4'h0, 4'h1, 4'h0, 4'h1, 4'h0};
`ifdef TOGGLE_MON_SAT_EN
    vt[0].ec = '{7, 0, 0, 0};
`else
    vt[0].ec = '{0, 0, 0, 0};
`endif
    vt[0].et = 8; vt[0].hold_idx = -1; vt[0].hold_n = 0; vt[0].pulse = 0; vt[0].end_start = 0;

    vt[1].s  = '{4'h4, 4'hE, 4'hE, 4'hC, 4'hC, 4'hE, 4'hE, 4'hC, 4'hC};
    vt[1].ec = '{0, 4, 0, 1};
    vt[1].et = 5; vt[1].hold_idx = 1; vt[1].hold_n = 3; vt[1].pulse = 0; vt[1].end_start = 0;

    vt[2] = vt[1];
    vt[2].hold_idx = -1; vt[2].hold_n = 0; vt[2].pulse = 1; vt[2].end_start = 1;

    vt[3].s = '{4'h0, 4'hF, 4'h0, 4'hF, 4'h0, 4'hF, 4'h0, 4'hF, 4'h0};
`ifdef TOGGLE_MON_SAT_EN
    vt[3].ec = '{7, 7, 7, 7}; vt[3].et = 31;
`else
    vt[3].ec = '{0, 0, 0, 0}; vt[3].et = 0;
`endif
    vt[3].hold_idx = 3; vt[3].hold_n = 1; vt[3].pulse = 0; vt[3].end_start = 0;

    vt[4].s  = '{4'h0, 4'h4, 4'h0, 4'h4, 4'h0, 4'h4, 4'h0, 4'h4, 4'h4};
    vt[4].ec = '{0, 0, 7, 0};
    vt[4].et = 7; vt[4].hold_idx = 0; vt[4].hold_n = 2; vt[4].pulse = 0; vt[4].end_start = 0;

    rst = 1'b0; start = 1'b0; res_ready = 1'b0; nets_in = '0;

    // Asynchronous reset raised between clock edges
    #3 rst = 1'b1;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_valid", res_valid, 0);
    chk("rst_idx", res_idx, 0);
    chk("rst_count", res_count, 0);
    chk("rst_last", res_last, 0);
    chk("rst_total", total_count, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_valid", res_valid, 0);
    $display("reset checks done");

    for (int v = 0; v < 5; v++) begin
      load_vec(v);
      $display("directed window %0d", v);
      run_window(vt[v].hold_idx, vt[v].hold_n, vt[v].pulse, vt[v].end_start, -1);
    end

    // Reset during DRAIN at index 2, then a fresh window must start from zero
    load_vec(1);
    run_window(-1, 0, 0, 0, 2);
    repeat (2) @(negedge clk);
    load_vec(4);
    $display("window after abort");
    run_window(-1, 0, 0, 0, -1);

    // Random windows checked against the reference model
    for (int r = 0; r < 20; r++) begin
      for (int j = 0; j <= WL; j++) cur_samp[j] = N'($urandom);
      model();
      $display("random window %0d", r);
      run_window($urandom_range(0, N - 1), $urandom_range(0, 2), r[0], 0, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
